bsg_link_isdr_rx_buffer: RTL and testbench

Receive-side buffer directly downstream of the input SDR capture PHY. It runs on the PHY's buffered capture clock and accepts one {valid, data} word per cycle from the capture flops. It holds the words in a small FIFO and presents them to the core with a valid/yumi handshake. For every 2^lg_credit_to_token_decimation_p words the core consumes, it toggles token_o to return credits to the upstream transmitter.

---
 rtl/bsg_link_isdr_rx_buffer_if.sv | 26 ++
 rtl/bsg_link_isdr_rx_buffer.sv | 85 ++++++++
 tb/tb_bsg_link_isdr_rx_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bsg_link_isdr_rx_buffer_if.sv
// Link-side and core-side signals of the SDR receive buffer.
// The link side carries captured {valid, data} words from the PHY.
// The core side carries the valid/yumi handshake plus token and overflow status.
interface bsg_link_isdr_rx_buffer_if #(
    parameter int width_p = 16
);
    logic               link_v_i;
    logic [width_p-1:0] link_data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               token_o;
    logic               overflow_o;

    // Driver side: the PHY capture flops, the core and the link layer.
    modport master (
        output link_v_i, link_data_i, yumi_i,
        input  v_o, data_o, token_o, overflow_o
    );

    // Buffer side.
    modport slave (
        input  link_v_i, link_data_i, yumi_i,
        output v_o, data_o, token_o, overflow_o
    );
endinterface

// File: rtl/bsg_link_isdr_rx_buffer.sv
// Receive buffer behind the input SDR capture PHY, clocked by the capture clock.
// Captured words are queued in a circular FIFO and handed to the core over valid/yumi.
// token_o toggles once per 2^lg_credit_to_token_decimation_p consumed words so the
// upstream transmitter gets its credits back. A word that arrives while the FIFO is
// full is dropped, and the drop sets the sticky overflow_o flag.
module bsg_link_isdr_rx_buffer #(
    parameter int width_p                         = 16,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_link_isdr_rx_buffer_if.slave    link
);
    localparam int depth_lp = 1 << lg_fifo_depth_p;
    localparam int ptr_w_lp = lg_fifo_depth_p + 1;

    if (lg_credit_to_token_decimation_p > lg_fifo_depth_p) begin : g_bad_decimation
        $error("lg_credit_to_token_decimation_p must not exceed lg_fifo_depth_p");
    end

    logic [width_p-1:0]  mem_r [depth_lp];
    logic [ptr_w_lp-1:0] rptr_r, wptr_r;
    logic                token_r, overflow_r;
    logic                empty, full, deq, enq, drop, token_wrap;

    // The extra pointer MSB tells full (MSBs differ) apart from empty (pointers equal).
    assign empty = (rptr_r == wptr_r);
    assign full  = ((rptr_r ^ wptr_r) == {1'b1, {lg_fifo_depth_p{1'b0}}});

    // A yumi_i on an empty FIFO is ignored. A full FIFO accepts a word only when the
    // head leaves in the same cycle.
    assign deq  = link.yumi_i & ~empty;
    assign enq  = link.link_v_i & (~full | link.yumi_i);
    assign drop = link.link_v_i & full & ~link.yumi_i;

    assign link.v_o        = ~empty;
    assign link.data_o     = mem_r[rptr_r[lg_fifo_depth_p-1:0]];
    assign link.token_o    = token_r;
    assign link.overflow_o = overflow_r;

    // Write the accepted word into the slot at the write pointer.
    // NOTE: storage has no reset. Clearing the pointers makes every entry unreachable,
    // and leaving the array unreset lets synthesis map it onto plain RAM or flops.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) begin
            mem_r[wptr_r[lg_fifo_depth_p-1:0]] <= link.link_data_i;
        end
    end

    // Advance the pointers, set the sticky overflow flag, and toggle the token on each
    // counter wrap.
    // NOTE: all state here updates with non-blocking assignments, so every term on the
    // right-hand side sees its value from before the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r     <= '0;
            wptr_r     <= '0;
            token_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (enq)               wptr_r     <= wptr_r + ptr_w_lp'(1);
            if (deq)               rptr_r     <= rptr_r + ptr_w_lp'(1);
            if (drop)              overflow_r <= 1'b1;
            if (deq && token_wrap) token_r    <= ~token_r;
        end
    end

    if (lg_credit_to_token_decimation_p == 0) begin : g_no_decimation
        assign token_wrap = 1'b1;
    end else begin : g_decimation
        logic [lg_credit_to_token_decimation_p-1:0] cnt_r;

        // Count dequeues. The dequeue that finds the counter at all ones wraps it to 0.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_r <= '0;
            end else if (deq) begin
                cnt_r <= cnt_r + lg_credit_to_token_decimation_p'(1);
            end
        end

        assign token_wrap = &cnt_r;
    end
endmodule

// File: tb/tb_bsg_link_isdr_rx_buffer.sv
// Self-checking bench for bsg_link_isdr_rx_buffer.
// Two buffers, one with decimation 0 and one with decimation 2, get identical stimulus.
// A shared scoreboard queue holds the words each buffer should deliver. Separate token
// models track the expected token_o of each buffer.
module tb_bsg_link_isdr_rx_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        link_v = 1'b0;
    logic [15:0] link_data = '0;
    logic        yumi = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q[$];
    logic        exp_tok0 = 1'b0;
    logic        exp_tok2 = 1'b0;
    logic        exp_ovf  = 1'b0;
    int          cnt2     = 0;

    always #5 clk = ~clk;

    bsg_link_isdr_rx_buffer_if #(.width_p(16)) if0 ();
    bsg_link_isdr_rx_buffer_if #(.width_p(16)) if2 ();

    assign if0.link_v_i    = link_v;
    assign if0.link_data_i = link_data;
    assign if0.yumi_i      = yumi;
    assign if2.link_v_i    = link_v;
    assign if2.link_data_i = link_data;
    assign if2.yumi_i      = yumi;

    bsg_link_isdr_rx_buffer #(
        .width_p(16), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(0)
    ) dut0 (
        .clk_i(clk), .reset_i(rst), .link(if0)
    );

    bsg_link_isdr_rx_buffer #(
        .width_p(16), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(2)
    ) dut2 (
        .clk_i(clk), .reset_i(rst), .link(if2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare the outputs of both buffers with the model state.
    task automatic check_status();
        check("v0",   32'(if0.v_o),        32'(q.size() != 0));
        check("v2",   32'(if2.v_o),        32'(q.size() != 0));
        check("tok0", 32'(if0.token_o),    32'(exp_tok0));
        check("tok2", 32'(if2.token_o),    32'(exp_tok2));
        check("ovf0", 32'(if0.overflow_o), 32'(exp_ovf));
        check("ovf2", 32'(if2.overflow_o), 32'(exp_ovf));
        if (q.size() != 0) begin
            check("head0", 32'(if0.data_o), 32'(q[0]));
            check("head2", 32'(if2.data_o), 32'(q[0]));
        end
    endtask

    // Drive one cycle of stimulus, update the model for that edge, then check.
    task automatic step(input logic lv, input logic [15:0] d, input logic y);
        logic do_deq, do_enq;
        @(negedge clk);
        link_v    = lv;
        link_data = d;
        yumi      = y;
        do_deq = y && (q.size() != 0);
        do_enq = lv && ((q.size() < 8) || y);
        if (lv && (q.size() == 8) && !y) exp_ovf = 1'b1;
        if (do_deq) begin
            check("deq_data0", 32'(if0.data_o), 32'(q[0]));
            check("deq_data2", 32'(if2.data_o), 32'(q[0]));
            void'(q.pop_front());
            exp_tok0 = ~exp_tok0;
            cnt2 = (cnt2 + 1) % 4;
            if (cnt2 == 0) exp_tok2 = ~exp_tok2;
        end
        if (do_enq) q.push_back(d);
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Hold reset for n edges with link_v and yumi active. Both must be ignored.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        link_v    = 1'b1;
        link_data = 16'hFFFF;
        yumi      = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        link_v = 1'b0;
        yumi   = 1'b0;
        q.delete();
        exp_tok0 = 1'b0;
        exp_tok2 = 1'b0;
        exp_ovf  = 1'b0;
        cnt2     = 0;
        check_status();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with link traffic present.
        do_reset(3);
        check("rst_v0",   32'(if0.v_o), 32'd0);
        check("rst_tok0", 32'(if0.token_o), 32'd0);
        check("rst_ovf0", 32'(if0.overflow_o), 32'd0);

        // Single word, then a dequeue that toggles the decimation-0 token.
        step(1'b1, 16'hA5A5, 1'b0);
        check("single_v",    32'(if0.v_o), 32'd1);
        check("single_data", 32'(if0.data_o), 32'hA5A5);
        step(1'b0, 16'h0000, 1'b1);
        check("single_v_after", 32'(if0.v_o), 32'd0);
        check("single_tok",     32'(if0.token_o), 32'd1);

        // Full FIFO with enqueue and dequeue in the same cycle: no overflow.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0010 + i), 1'b0);
        step(1'b1, 16'h1234, 1'b1);
        check("full_simul_ovf", 32'(if0.overflow_o), 32'd0);
        check("full_simul_v",   32'(if0.v_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("last_word", 32'(if0.data_o), 32'h1234);
            step(1'b0, 16'h0000, 1'b1);
        end
        check("drain1_empty", 32'(if0.v_o), 32'd0);

        // Fill to capacity, then overflow with a ninth word, then drain in order.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'h0008, 1'b0);
        check("overflow_set", 32'(if0.overflow_o), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1);
        check("drain2_empty", 32'(if0.v_o), 32'd0);
        step(1'b0, 16'h0000, 1'b1);
        check("overflow_sticky", 32'(if2.overflow_o), 32'd1);

        // Decimation 2: the token toggles only on the 4th and 8th dequeues.
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            if (i == 3) check("dec_tok_3", 32'(if2.token_o), 32'd0);
            if (i == 4) check("dec_tok_4", 32'(if2.token_o), 32'd1);
            if (i == 7) check("dec_tok_7", 32'(if2.token_o), 32'd1);
            if (i == 8) check("dec_tok_8", 32'(if2.token_o), 32'd0);
        end

        // Reset mid-operation with the decimation counter at 3.
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0200 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
        do_reset(1);
        check("midrst_v", 32'(if2.v_o), 32'd0);
        step(1'b1, 16'h0BEE, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
        check("midrst_tok2", 32'(if2.token_o), 32'd0);
        check("midrst_empty", 32'(if2.v_o), 32'd0);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
